spi_master: RTL

- SPI master: the initiating end of the link served by the voltmeter's SPI slave.
- Used in the validation/bring-up harness to drive 32-bit frames into digital_top over spi_sclk/spi_cs/spi_mosi and capture spi_miso.
- Later reused to poll an external reference/ADC part.
- Full-duplex, MSB-first, configurable mode, one frame per start request.

---
 rtl/spi_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master: full-duplex, MSB-first, one N-bit frame per accepted start.
// Chip select, SCLK and MOSI all come straight from flops so the pins are glitch-free.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | CS high, SCLK at CPOL, waiting for start_i
//   S_SETUP | CS low, SCLK parked, CS_SETUP cycles before the first SCLK edge
//   S_SHIFT | 2*N SCLK edges, one every CLK_DIV cycles; last edge ends the state
//   S_HOLD  | SCLK parked, CS still low for CS_HOLD cycles
//   S_DONE  | CS high, done_o pulse, rx_data_o updated; back to idle next cycle
module spi_master #(
   parameter int unsigned N        = 32,
   parameter logic        CPOL     = 1'b0,
   parameter logic        CPHA     = 1'b0,
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [N-1:0] tx_data_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] rx_data_o,
   output logic         spi_sclk_o,
   output logic         spi_cs_o,
   output logic         spi_mosi_o,
   input  logic         spi_miso_i
);

   localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int unsigned PW     = $clog2(PH_MAX + 1);
   localparam int unsigned DW     = $clog2(CLK_DIV + 1);
   localparam int unsigned EW     = $clog2(2 * N + 1);

   localparam logic [PW-1:0] SETUP_LD = PW'(CS_SETUP - 1);
   localparam logic [PW-1:0] HOLD_LD  = PW'(CS_HOLD - 1);
   localparam logic [DW-1:0] DIV_LD   = DW'(CLK_DIV - 1);
   localparam logic [EW-1:0] EDGES    = EW'(2 * N);
   localparam logic [EW-1:0] LAST_EDGE = EW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t         state;
   logic [PW-1:0]  ph_cnt;
   logic [DW-1:0]  div_cnt;
   logic [EW-1:0]  edge_rem;
   logic [N-1:0]   tx_sr;
   logic [N-1:0]   rx_sr;

   // Frame sequencer; edge_rem counts SCLK edges still to come, so an even
   // value means the next toggle is a leading edge and 1 means the final edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= S_IDLE;
         ph_cnt     <= '0;
         div_cnt    <= '0;
         edge_rem   <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         rx_data_o  <= '0;
         spi_sclk_o <= CPOL;
         spi_cs_o   <= 1'b1;
         spi_mosi_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  tx_sr    <= tx_data_i;
                  rx_sr    <= '0;
                  spi_cs_o <= 1'b0;
                  busy_o   <= 1'b1;
                  if (CPHA == 1'b0) spi_mosi_o <= tx_data_i[N-1];
                  ph_cnt   <= SETUP_LD;
                  state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (ph_cnt == '0) begin
                  div_cnt  <= DIV_LD;
                  edge_rem <= EDGES;
                  state    <= S_SHIFT;
               end else begin
                  ph_cnt <= ph_cnt - PW'(1);
               end
            end
            S_SHIFT: begin
               if (div_cnt == '0) begin
                  div_cnt    <= DIV_LD;
                  spi_sclk_o <= ~spi_sclk_o;
                  if (edge_rem[0] == 1'b0) begin
                     if (CPHA == 1'b0) begin
                        rx_sr <= {rx_sr[N-2:0], spi_miso_i};
                     end else begin
                        spi_mosi_o <= tx_sr[N-1];
                        tx_sr      <= {tx_sr[N-2:0], 1'b0};
                     end
                  end else begin
                     if (CPHA == 1'b0) begin
                        // MOSI stays put after the final trailing edge
                        if (edge_rem != LAST_EDGE) begin
                           spi_mosi_o <= tx_sr[N-2];
                           tx_sr      <= {tx_sr[N-2:0], 1'b0};
                        end
                     end else begin
                        rx_sr <= {rx_sr[N-2:0], spi_miso_i};
                     end
                  end
                  if (edge_rem == LAST_EDGE) begin
                     ph_cnt <= HOLD_LD;
                     state  <= S_HOLD;
                  end else begin
                     edge_rem <= edge_rem - EW'(1);
                  end
               end else begin
                  div_cnt <= div_cnt - DW'(1);
               end
            end
            S_HOLD: begin
               if (ph_cnt == '0) begin
                  spi_cs_o  <= 1'b1;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  rx_data_o <= rx_sr;
                  state     <= S_DONE;
               end else begin
                  ph_cnt <= ph_cnt - PW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
